mem_stage: RTL

- Pipeline MEM stage, directly downstream of the EX stage (ALU + ALU control); consumes the ALU result as a byte address plus the rt store data.
- Performs byte, halfword and word loads/stores (LB, LH, LHU, LW, LWU, LBU, SB, SH, SW) against an internal byte-lane data memory.
- Registers everything into the MEM/WB pipeline register for the WB stage.
- Exposes a debug read port for the debug unit.

---
 rtl/mem_stage_pkg.sv | 57 +++++
 rtl/mem_stage_data_memory.sv | 53 +++++
 rtl/mem_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, load/store opcodes
// and small decode helpers also used by the ID-stage control unit.
package mem_stage_pkg;

    localparam int DEFAULT_NB_REG       = 32;
    localparam int DEFAULT_NB_WORD_ADDR = 7;
    localparam int DEFAULT_NB_REG_ADDR  = 5;
    localparam int NB_LANES             = 4;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_RSVD = 2'b10,
        MEM_SIZE_WORD = 2'b11
    } mem_size_e;

    localparam logic [5:0] OPCODE_LB  = 6'b100000;
    localparam logic [5:0] OPCODE_LH  = 6'b100001;
    localparam logic [5:0] OPCODE_LW  = 6'b100011;
    localparam logic [5:0] OPCODE_LBU = 6'b100100;
    localparam logic [5:0] OPCODE_LHU = 6'b100101;
    localparam logic [5:0] OPCODE_LWU = 6'b100111;
    localparam logic [5:0] OPCODE_SB  = 6'b101000;
    localparam logic [5:0] OPCODE_SH  = 6'b101001;
    localparam logic [5:0] OPCODE_SW  = 6'b101011;

    function automatic mem_size_e mem_size_of_opcode(input logic [5:0] opcode);
        mem_size_e size;
        case (opcode)
            OPCODE_LB, OPCODE_LBU, OPCODE_SB: size = MEM_SIZE_BYTE;
            OPCODE_LH, OPCODE_LHU, OPCODE_SH: size = MEM_SIZE_HALF;
            default:                          size = MEM_SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic mem_unsigned_of_opcode(input logic [5:0] opcode);
        logic is_unsigned;
        case (opcode)
            OPCODE_LBU, OPCODE_LHU, OPCODE_LWU: is_unsigned = 1'b1;
            default:                            is_unsigned = 1'b0;
        endcase
        return is_unsigned;
    endfunction

    // The reserved size code behaves as a word access, so it needs word alignment.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = lane[0];
            default:       mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-lane data memory: combinational read-before-write access port, registered
// debug read port, whole-array synchronous clear on reset.
module mem_stage_data_memory
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA = DEFAULT_NB_REG,
    parameter int NB_ADDR = DEFAULT_NB_WORD_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_LANES-1:0] i_we,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_rdata,
    input  logic [NB_ADDR-1:0] i_du_addr,
    output logic [NB_DATA-1:0] o_du_data
);

    localparam int DEPTH   = 2 ** NB_ADDR;
    localparam int NB_LANE = NB_DATA / NB_LANES;

    logic [NB_DATA-1:0] mem_r [DEPTH];
    logic [NB_DATA-1:0] du_data_r;

    // The access port sees the array before this edge's write lands.
    assign o_rdata   = mem_r[i_addr];
    assign o_du_data = du_data_r;

    // Array update: reset clears every word, otherwise only enabled byte lanes are written.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {NB_DATA{1'b0}};
            end
        end else begin
            for (int b = 0; b < NB_LANES; b++) begin
                if (i_we[b]) begin
                    mem_r[i_addr][b*NB_LANE +: NB_LANE] <= i_wdata[b*NB_LANE +: NB_LANE];
                end
            end
        end
    end

    // Debug read port, refreshed every cycle with the pre-write word.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            du_data_r <= {NB_DATA{1'b0}};
        end else begin
            du_data_r <= mem_r[i_du_addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte/half/word loads and stores against the data memory,
// load extension, and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_REG       = DEFAULT_NB_REG,
    parameter int NB_WORD_ADDR = DEFAULT_NB_WORD_ADDR,
    parameter int NB_REG_ADDR  = DEFAULT_NB_REG_ADDR
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [NB_REG-1:0]       i_alu_result,
    input  logic [NB_REG-1:0]       i_write_data,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [1:0]              i_mem_size,
    input  logic                    i_mem_unsigned,
    input  logic                    i_reg_write,
    input  logic                    i_mem_to_reg,
    input  logic [NB_REG_ADDR-1:0]  i_rd,
    input  logic [NB_WORD_ADDR-1:0] i_du_addr,
    output logic [NB_REG-1:0]       o_mem_data,
    output logic [NB_REG-1:0]       o_alu_result,
    output logic [NB_REG_ADDR-1:0]  o_rd,
    output logic                    o_reg_write,
    output logic                    o_mem_to_reg,
    output logic                    o_misaligned,
    output logic [NB_REG-1:0]       o_du_data
);

    logic [NB_WORD_ADDR-1:0] word_idx_s;
    logic [1:0]              lane_s;
    mem_size_e               size_s;
    logic                    misaligned_s;
    logic                    mis_flag_s;
    logic                    reg_write_s;
    logic [NB_LANES-1:0]     we_s;
    logic [NB_REG-1:0]       wdata_s;
    logic [NB_REG-1:0]       rdata_s;
    logic [7:0]              byte_s;
    logic [15:0]             half_s;
    logic [NB_REG-1:0]       mem_data_s;

    logic [NB_REG-1:0]       mem_data_r;
    logic [NB_REG-1:0]       alu_result_r;
    logic [NB_REG_ADDR-1:0]  rd_r;
    logic                    reg_write_r;
    logic                    mem_to_reg_r;
    logic                    misaligned_r;

    // Upper address bits are deliberately dropped so addresses wrap around the memory.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^i_alu_result[NB_REG-1:NB_WORD_ADDR+2];

    assign word_idx_s   = i_alu_result[NB_WORD_ADDR+1:2];
    assign lane_s       = i_alu_result[1:0];
    assign size_s       = mem_size_e'(i_mem_size);
    assign misaligned_s = is_misaligned(size_s, lane_s);
    assign mis_flag_s   = (i_mem_read | i_mem_write) & misaligned_s;
    assign reg_write_s  = i_reg_write & ~(i_mem_read & misaligned_s);

    // Store lane enables and lane-replicated write data.
    always_comb begin
        we_s    = {NB_LANES{1'b0}};
        wdata_s = i_write_data;
        if (i_enable && i_mem_write && !misaligned_s) begin
            case (size_s)
                MEM_SIZE_BYTE: begin
                    we_s    = 4'b0001 << lane_s;
                    wdata_s = {(NB_REG/8){i_write_data[7:0]}};
                end
                MEM_SIZE_HALF: begin
                    we_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {(NB_REG/16){i_write_data[15:0]}};
                end
                default: begin
                    we_s    = 4'b1111;
                    wdata_s = i_write_data;
                end
            endcase
        end else begin
            we_s    = {NB_LANES{1'b0}};
            wdata_s = i_write_data;
        end
    end

    mem_stage_data_memory #(
        .NB_DATA (NB_REG),
        .NB_ADDR (NB_WORD_ADDR)
    ) u_data_memory (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_we      (we_s),
        .i_addr    (word_idx_s),
        .i_wdata   (wdata_s),
        .o_rdata   (rdata_s),
        .i_du_addr (i_du_addr),
        .o_du_data (o_du_data)
    );

    // Lane selection and sign/zero extension of the pre-write word.
    always_comb begin
        byte_s     = 8'h00;
        half_s     = lane_s[1] ? rdata_s[31:16] : rdata_s[15:0];
        mem_data_s = {NB_REG{1'b0}};
        case (lane_s)
            2'b00:   byte_s = rdata_s[7:0];
            2'b01:   byte_s = rdata_s[15:8];
            2'b10:   byte_s = rdata_s[23:16];
            default: byte_s = rdata_s[31:24];
        endcase
        if (i_mem_read && !misaligned_s) begin
            case (size_s)
                MEM_SIZE_BYTE: mem_data_s = i_mem_unsigned ? {{(NB_REG-8){1'b0}}, byte_s}
                                                           : {{(NB_REG-8){byte_s[7]}}, byte_s};
                MEM_SIZE_HALF: mem_data_s = i_mem_unsigned ? {{(NB_REG-16){1'b0}}, half_s}
                                                           : {{(NB_REG-16){half_s[15]}}, half_s};
                default:       mem_data_s = rdata_s;
            endcase
        end else begin
            mem_data_s = {NB_REG{1'b0}};
        end
    end

    // MEM/WB pipeline register: reset wins, otherwise advance only when enabled.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mem_data_r   <= {NB_REG{1'b0}};
            alu_result_r <= {NB_REG{1'b0}};
            rd_r         <= {NB_REG_ADDR{1'b0}};
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            misaligned_r <= 1'b0;
        end else if (i_enable) begin
            mem_data_r   <= mem_data_s;
            alu_result_r <= i_alu_result;
            rd_r         <= i_rd;
            reg_write_r  <= reg_write_s;
            mem_to_reg_r <= i_mem_to_reg;
            misaligned_r <= mis_flag_s;
        end else begin
            mem_data_r   <= mem_data_r;
            alu_result_r <= alu_result_r;
            rd_r         <= rd_r;
            reg_write_r  <= reg_write_r;
            mem_to_reg_r <= mem_to_reg_r;
            misaligned_r <= misaligned_r;
        end
    end

    assign o_mem_data   = mem_data_r;
    assign o_alu_result = alu_result_r;
    assign o_rd         = rd_r;
    assign o_reg_write  = reg_write_r;
    assign o_mem_to_reg = mem_to_reg_r;
    assign o_misaligned = misaligned_r;

endmodule
